// File: rtl/iir_out_packer_if.sv
// iir_out_packer_if
//   Groups the filter output stream and the result-memory write port of
//   iir_out_packer.
//   Stream : WEN, WAddr[19:0], Yn[15:0] (signed), Finish (level)
//   Memory : mem_ready (in to packer), mem_wr, mem_addr[18:0], mem_wdata[31:0]
//   master : producer side (filter + memory model, e.g. a testbench)
//   slave  : the packer itself
interface iir_out_packer_if;
    logic        WEN;
    logic [19:0] WAddr;
    logic [15:0] Yn;
    logic        Finish;
    logic        mem_ready;
    logic        mem_wr;
    logic [18:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output WEN, WAddr, Yn, Finish, mem_ready,
        input  mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        input  WEN, WAddr, Yn, Finish, mem_ready,
        output mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/iir_out_packer.sv
// iir_out_packer
//   Packs pairs of 16-bit filter samples into 32-bit words, buffers them in a
//   DEPTH-entry FIFO and writes them to a ready-throttled result memory.
//   Tracks address sequence errors, FIFO overflow and peak |Yn|; raises done
//   once every accepted sample has been written.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous, active-high reset
//   bus      : stream in (WEN/WAddr/Yn/Finish) and memory port
//              (mem_ready in, mem_wr/mem_addr/mem_wdata out)
//   done     : all accepted data written (sticky)
//   overflow : a word was dropped because the FIFO was full (sticky)
//   seq_err  : address sequence broken or pending sample lost (sticky)
//   peak     : max |Yn| over accepted samples, unsigned, saturated
module iir_out_packer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    iir_out_packer_if.slave    bus,
    output logic               done,
    output logic               overflow,
    output logic               seq_err,
    output logic [15:0]        peak
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_pend_vld;
    logic [15:0] r_pend_data;
    logic [18:0] r_pend_addr;
    logic [19:0] r_exp_addr;
    logic        r_overflow;
    logic        r_seq_err;
    logic [15:0] r_peak;

    logic [50:0] r_fifo [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic        w_accept;
    logic [18:0] w_word_addr;
    logic [15:0] w_low;
    logic [15:0] w_abs;
    logic        w_push;
    logic [50:0] w_push_entry;
    logic        w_pop;
    logic        w_full;
    logic        w_push_ok;

    assign w_accept    = (r_state == S_RUN) && bus.WEN;
    assign w_word_addr = bus.WAddr[19:1];
    // Low half only pairs with the odd sample if it belongs to the same word.
    assign w_low       = (r_pend_vld && (r_pend_addr == w_word_addr)) ? r_pend_data : '0;
    // -32768 has no positive 16-bit counterpart; clamp to 32767.
    assign w_abs       = (bus.Yn == 16'h8000) ? 16'h7FFF :
                         (bus.Yn[15] ? (~bus.Yn + 16'd1) : bus.Yn);

    assign w_pop     = (r_count != '0) && bus.mem_ready;
    assign w_full    = (r_count == FULL_CNT);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_push_entry = '0;
        case (r_state)
            S_RUN: begin
                if (w_accept && bus.WAddr[0]) begin
                    w_push       = 1'b1;
                    w_push_entry = {w_word_addr, bus.Yn, w_low};
                end
                if (bus.Finish) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_pend_vld) begin
                    w_push       = 1'b1;
                    w_push_entry = {r_pend_addr, 16'h0000, r_pend_data};
                end
                w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_count == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_DONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_pend_vld  <= 1'b0;
            r_pend_data <= '0;
            r_pend_addr <= '0;
            r_exp_addr  <= '0;
            r_overflow  <= 1'b0;
            r_seq_err   <= 1'b0;
            r_peak      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                // Mismatch, or an even sample overwriting an unpaired one.
                if ((bus.WAddr != r_exp_addr) || (!bus.WAddr[0] && r_pend_vld)) begin
                    r_seq_err <= 1'b1;
                end
                r_exp_addr <= bus.WAddr + 20'd1;
                if (w_abs > r_peak) begin
                    r_peak <= w_abs;
                end
                if (!bus.WAddr[0]) begin
                    r_pend_vld  <= 1'b1;
                    r_pend_data <= bus.Yn;
                    r_pend_addr <= w_word_addr;
                end else begin
                    r_pend_vld  <= 1'b0;
                end
            end else if (r_state == S_FLUSH) begin
                r_pend_vld <= 1'b0;
            end

            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= w_push_entry;
        end
    end

    assign bus.mem_wr    = (r_count != '0);
    assign bus.mem_addr  = r_fifo[r_rd_ptr][50:32];
    assign bus.mem_wdata = r_fifo[r_rd_ptr][31:0];

    assign done     = (r_state == S_DONE);
    assign overflow = r_overflow;
    assign seq_err  = r_seq_err;
    assign peak     = r_peak;
endmodule

// File: tb/tb_iir_out_packer.sv
module tb_iir_out_packer;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iir_out_packer_if bus();
    logic        done;
    logic        overflow;
    logic        seq_err;
    logic [15:0] peak;

    iir_out_packer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .done     (done),
        .overflow (overflow),
        .seq_err  (seq_err),
        .peak     (peak)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: spec rules on plain variables and a queue FIFO.
    int          m_phase;   // 0 run, 1 flush, 2 drain, 3 done
    bit          m_pv;
    logic [15:0] m_pd;
    logic [18:0] m_pa;
    logic [19:0] m_exp;
    logic [50:0] m_q[$];
    bit          m_ovf;
    bit          m_seq;
    logic [15:0] m_peak;

    logic [50:0] got[$];    // words seen written by the DUT

    typedef struct packed {
        logic [2:0][15:0] s;
        logic [1:0]       n;
        logic [15:0]      exp_peak;
    } pk_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit wen, input logic [19:0] wa,
                              input logic [15:0] yn, input bit fin, input bit rdy);
        bit pop;
        bit push;
        logic [50:0] item;
        int sz;
        int v;
        int a;
        if (r) begin
            m_phase = 0; m_pv = 0; m_pd = '0; m_pa = '0; m_exp = '0;
            m_q.delete(); m_ovf = 0; m_seq = 0; m_peak = '0;
            return;
        end
        sz   = m_q.size();
        pop  = (sz > 0) && rdy;
        push = 0;
        item = '0;
        case (m_phase)
            0: begin
                if (wen) begin
                    if (wa != m_exp) m_seq = 1;
                    m_exp = wa + 20'd1;
                    v = int'($signed(yn));
                    a = (v < 0) ? -v : v;
                    if (a > 32767) a = 32767;
                    if (a > int'(m_peak)) m_peak = 16'(a);
                    if (wa % 2 == 0) begin
                        if (m_pv) m_seq = 1;
                        m_pv = 1;
                        m_pd = yn;
                        m_pa = 19'(wa / 2);
                    end else begin
                        push = 1;
                        item = {19'(wa / 2), yn, (m_pv && m_pa == 19'(wa / 2)) ? m_pd : 16'h0000};
                        m_pv = 0;
                    end
                end
                if (fin) m_phase = 1;
            end
            1: begin
                if (m_pv) begin
                    push = 1;
                    item = {m_pa, 16'h0000, m_pd};
                end
                m_pv = 0;
                m_phase = 2;
            end
            2: if (sz == 0) m_phase = 3;
            default: ;
        endcase
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (sz < int'(DEPTH) || pop) m_q.push_back(item);
            else m_ovf = 1;
        end
    endtask

    // One clock: log any write, advance model, compare all outputs.
    task automatic step();
        bit r, wen, fin, rdy;
        logic [19:0] wa;
        logic [15:0] yn;
        logic [51:0] e_mem;
        logic [51:0] a_mem;
        r = rst; wen = bus.WEN; fin = bus.Finish; rdy = bus.mem_ready;
        wa = bus.WAddr; yn = bus.Yn;
        if (bus.mem_wr === 1'b1 && bus.mem_ready === 1'b1)
            got.push_back({bus.mem_addr, bus.mem_wdata});
        @(posedge clk);
        #1;
        model_step(r, wen, wa, yn, fin, rdy);
        e_mem = (m_q.size() > 0) ? {1'b1, m_q[0]} : '0;
        a_mem = {bus.mem_wr, (bus.mem_wr === 1'b1) ? {bus.mem_addr, bus.mem_wdata} : 51'h0};
        chk("mem_port", 64'(a_mem), 64'(e_mem));
        chk("status", 64'({done, overflow, seq_err, peak}),
            64'({m_phase == 3, m_ovf, m_seq, m_peak}));
    endtask

    task automatic idle();
        bus.WEN = 1'b0;
        bus.Finish = 1'b0;
        step();
    endtask

    task automatic send(input logic [19:0] a, input logic [15:0] y);
        bus.WEN = 1'b1;
        bus.WAddr = a;
        bus.Yn = y;
        bus.Finish = 1'b0;
        step();
        bus.WEN = 1'b0;
    endtask

    task automatic finish_pulse();
        bus.Finish = 1'b1;
        step();
        bus.Finish = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("done_reached", 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.WEN = 1'b0;
        bus.Finish = 1'b0;
        step();
        step();
        rst = 1'b0;
        got.delete();
    endtask

    function automatic logic [63:0] gw(input int i);
        return (i < got.size()) ? 64'(got[i]) : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    pk_vec_t pk_tab [6];

    initial begin
        bus.WEN = 1'b0; bus.WAddr = '0; bus.Yn = '0; bus.Finish = 1'b0; bus.mem_ready = 1'b1;

        pk_tab[0] = '{s: {16'hFFFF, 16'h8000, 16'h7000}, n: 2'd3, exp_peak: 16'h7FFF};
        pk_tab[1] = '{s: {16'h0000, 16'hFE00, 16'h0100}, n: 2'd2, exp_peak: 16'h0200};
        pk_tab[2] = '{s: {16'h0000, 16'h0000, 16'h0000}, n: 2'd1, exp_peak: 16'h0000};
        pk_tab[3] = '{s: {16'h0000, 16'h0001, 16'hFFFF}, n: 2'd2, exp_peak: 16'h0001};
        pk_tab[4] = '{s: {16'h0000, 16'h7FFE, 16'h8001}, n: 2'd2, exp_peak: 16'h7FFF};
        pk_tab[5] = '{s: {16'h0003, 16'hFFF0, 16'h0005}, n: 2'd3, exp_peak: 16'h0010};

        // Reset state
        do_reset();
        chk("reset_outs", 64'({bus.mem_wr, done, overflow, seq_err, peak}), 64'd0);

        // Eight samples, full words only
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(20'(i), 16'(i + 1));
        finish_pulse();
        wait_done(20);
        chk("t1_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("t1_word", gw(i), 64'({19'(i), 16'(2 * i + 2), 16'(2 * i + 1)}));
        chk("t1_flags", 64'({overflow, seq_err}), 64'd0);

        // Five samples, trailing half word flushed
        do_reset();
        for (int i = 0; i < 5; i++) send(20'(i), 16'h0A00 + 16'(i));
        chk("t2_not_done", 64'(done), 64'd0);
        finish_pulse();
        wait_done(20);
        chk("t2_count", 64'(got.size()), 64'd3);
        chk("t2_partial", gw(2), 64'({19'd2, 16'h0000, 16'h0A04}));

        // Stall: 12 samples + 8 idle with mem_ready low
        do_reset();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            send(20'(i), 16'h0010 + 16'(i));
            if (i >= 1)
                chk("stall_hold", 64'({bus.mem_wr, bus.mem_addr, bus.mem_wdata}),
                    64'({1'b1, 19'd0, 16'h0011, 16'h0010}));
        end
        for (int i = 0; i < 8; i++) begin
            idle();
            chk("stall_hold", 64'({bus.mem_wr, bus.mem_addr, bus.mem_wdata}),
                64'({1'b1, 19'd0, 16'h0011, 16'h0010}));
        end
        chk("stall_ovf", 64'(overflow), 64'd1);
        bus.mem_ready = 1'b1;
        finish_pulse();
        wait_done(30);
        chk("stall_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("stall_word", gw(i), 64'({19'(i), 16'h0010 + 16'(2 * i + 1), 16'h0010 + 16'(2 * i)}));

        // Address gap 0,1,2,5,6
        do_reset();
        send(20'd0, 16'hA000);
        send(20'd1, 16'hA001);
        send(20'd2, 16'hA002);
        chk("seq_before", 64'(seq_err), 64'd0);
        send(20'd5, 16'hA005);
        chk("seq_after", 64'(seq_err), 64'd1);
        send(20'd6, 16'hA006);
        finish_pulse();
        wait_done(20);
        chk("seq_count", 64'(got.size()), 64'd3);
        chk("seq_w0", gw(0), 64'({19'd0, 16'hA001, 16'hA000}));
        chk("seq_w2", gw(1), 64'({19'd2, 16'hA005, 16'h0000}));
        chk("seq_w3", gw(2), 64'({19'd3, 16'h0000, 16'hA006}));

        // Peak table
        foreach (pk_tab[t]) begin
            do_reset();
            for (int k = 0; k < int'(pk_tab[t].n); k++) send(20'(k), pk_tab[t].s[k]);
            chk("peak_tab", 64'(peak), 64'(pk_tab[t].exp_peak));
        end

        // Reset with two words queued
        do_reset();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(20'(i), 16'h0300 + 16'(i));
        chk("rst_pre_wr", 64'(bus.mem_wr), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid", 64'({bus.mem_wr, done, overflow, seq_err, peak}), 64'd0);
        got.delete();
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(20'(i), 16'h0400 + 16'(i));
        finish_pulse();
        wait_done(20);
        chk("rst_new_count", 64'(got.size()), 64'd2);
        chk("rst_new_flags", 64'({overflow, seq_err}), 64'd0);

        // Randomized streams against the model
        for (int run = 0; run < 25; run++) begin
            int len;
            logic [19:0] a;
            do_reset();
            len = $urandom_range(40, 3);
            a = '0;
            for (int i = 0; i < len; i++) begin
                bus.mem_ready = ($urandom_range(2, 0) != 0);
                if (run % 5 == 4 && i < 10) bus.mem_ready = 1'b0;
                if ($urandom_range(9, 0) == 0) a = 20'($urandom_range(15, 0));
                bus.Finish = (i == len - 1);
                if ($urandom_range(3, 0) != 0) begin
                    bus.WEN = 1'b1;
                    bus.WAddr = a;
                    bus.Yn = 16'($urandom());
                    a = a + 20'd1;
                end else begin
                    bus.WEN = 1'b0;
                end
                step();
            end
            for (int i = 0; i < 60 && done !== 1'b1; i++) begin
                bus.mem_ready = ($urandom_range(2, 0) != 0);
                bus.WEN = $urandom_range(1, 0) == 1;
                bus.WAddr = 20'($urandom_range(7, 0));
                bus.Yn = 16'($urandom());
                bus.Finish = $urandom_range(1, 0) == 1;
                step();
            end
            chk("rand_done", 64'(done), 64'd1);
            for (int i = 0; i < 3; i++) begin
                bus.WEN = 1'b1;
                bus.Yn = 16'h8000;
                bus.Finish = 1'b1;
                step();
            end
            bus.WEN = 1'b0;
            bus.Finish = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
